// File: rtl/i2c_target_regs.sv
// I2C target at one 7-bit address with an internal byte register file.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  localparam int        PTR_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] host_raddr,
  output logic [7:0]       host_rdata
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  logic scl_meta_q, scl_s_q, scl_p_q, sda_meta_q, sda_s_q, sda_p_q;
  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d;
  logic             first_q, first_d, wr_strobe_q, wr_strobe_d;
  logic [7:0]       regs_q [NUM_REGS];

  // Sync flops reset to the idle-bus level so no edge is seen on release
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_meta_q, scl_s_q, scl_p_q} <= 3'b111;
      {sda_meta_q, sda_s_q, sda_p_q} <= 3'b111;
    end else begin
      {scl_meta_q, scl_s_q, scl_p_q} <= {scl_i, scl_meta_q, scl_s_q};
      {sda_meta_q, sda_s_q, sda_p_q} <= {sda_i, sda_meta_q, sda_s_q};
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]       byte_in;
  logic [PTR_W-1:0] ptr_inc;
  assign scl_rise = scl_s_q & ~scl_p_q;
  assign scl_fall = ~scl_s_q & scl_p_q;
  assign start_c  = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop_c   = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;
  assign byte_in  = {shift_q[6:0], sda_s_q};
  assign ptr_inc  = ptr_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;         shift_d = shift_q;
    ptr_d = ptr_q;       sda_oe_d = sda_oe_q;   busy_d = busy_q;
    rw_d = rw_q;         first_d = first_q;     wr_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q; wr_data_d = wr_data_q;
    case (state_q)
      S_ADDR: begin
        if (scl_rise && cnt_q < 4'd8) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              busy_d = 1'b1;
              rw_d   = byte_in[0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (scl_fall && cnt_q == 4'd8) begin
          sda_oe_d = 1'b1;
          state_d  = S_ADDR_ACK;
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          if (rw_q) begin
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            cnt_d    = 4'd1;
            state_d  = S_RD_BYTE;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            first_d  = 1'b1;
            state_d  = S_WR_BYTE;
          end
        end
      end
      S_WR_BYTE: begin
        if (scl_rise && cnt_q < 4'd8) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (first_q) begin
              ptr_d   = byte_in[PTR_W-1:0];
              first_d = 1'b0;
            end else begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = byte_in;
              ptr_d       = ptr_inc;
            end
          end
        end else if (scl_fall && cnt_q == 4'd8) begin
          sda_oe_d = 1'b1;
          state_d  = S_WR_ACK;
        end
      end
      S_WR_ACK: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
          state_d  = S_WR_BYTE;
        end
      end
      S_RD_BYTE: begin
        if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_RD_ACK;
          end else begin
            sda_oe_d = ~shift_q[6];
            shift_d  = {shift_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end
        end
      end
      S_RD_ACK: begin
        // cnt=9 marks "master ACKed, next byte loaded, drive MSB at next fall"
        if (scl_rise && cnt_q == 4'd0) begin
          if (!sda_s_q) begin
            ptr_d   = ptr_inc;
            shift_d = regs_q[ptr_inc];
            cnt_d   = 4'd9;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = S_IDLE;
          end
        end else if (scl_fall && cnt_q == 4'd9) begin
          sda_oe_d = ~shift_q[7];
          cnt_d    = 4'd1;
          state_d  = S_RD_BYTE;
        end
      end
      default: ;
    endcase
    if (start_c) begin
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  cnt_q <= '0;     shift_q <= '0;   ptr_q <= '0;
      sda_oe_q <= 1'b0;   busy_q <= 1'b0;  rw_q <= 1'b0;    first_q <= 1'b0;
      wr_strobe_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0;
    end else begin
      state_q <= state_d;   cnt_q <= cnt_d;     shift_q <= shift_d; ptr_q <= ptr_d;
      sda_oe_q <= sda_oe_d; busy_q <= busy_d;   rw_q <= rw_d;       first_q <= first_d;
      wr_strobe_q <= wr_strobe_d; wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d;
    end
  end

  // Register file commits from the strobe, so host reads see it the clk after
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_strobe_q) begin
      regs_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_raddr];
endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
Synthesizable I2C target (slave) answering one 7-bit device address, backed by an internal byte-wide register file. It is the responder for the team's I2C master BFM and is the DUT that BFM drives in loopback benches. SCL and SDA are oversampled on the system clock. SDA is driven open-drain via an output-enable. A host-side port gives read access to the register file and reports each bus write.

Parameters:
DEV_ADDR, 7'h50, 7-bit target address matched against the address byte.
NUM_REGS, 16, register-file depth; power of 2, 2..256. PTR_W = log2(NUM_REGS) is derived.

Ports:
clk  in  1  system clock; must be >= 10x SCL frequency.
rst  in  1  synchronous, active-high reset.
scl_i  in  1  SCL pad input (asynchronous).
sda_i  in  1  SDA pad input (asynchronous).
sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z).
busy  out  1  high from address match to STOP, or to the next START.
wr_strobe  out  1  one-clk pulse per register written from the bus.
wr_addr  out  PTR_W  register index for wr_strobe.
wr_data  out  8  data for wr_strobe.
host_raddr  in  PTR_W  host read index.
host_rdata  out  8  regs[host_raddr], combinational.

Behaviour:
- Reset values: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, all regs=0, ptr=0, state=IDLE.
- Input conditioning: scl_i and sda_i each pass through a 2-FF synchronizer, then a third "previous" register for edge detection. All decisions use synced values.
- SCL rise/fall: synced SCL differs from its previous value.
- START: SDA 1->0 while SCL is high in both the previous and current sample.
- STOP: SDA 0->1 under the same SCL condition.
- START and STOP are checked in every state and override everything else.
  - START (including repeated START): go to ADDR, clear the bit counter, set sda_oe=0 in the same clk, clear busy.
  - STOP: go to IDLE, sda_oe=0, busy=0.
- SDA sampling and drive timing:
  - Data is sampled on SCL rise.
  - sda_oe changes only on SCL fall; START/STOP releases are the exception.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first. After the 8th rise, compare bits[7:1] with DEV_ADDR.
    - Match: set busy; at the next SCL fall assert sda_oe (ACK) and go to ADDR_ACK. Latch R/W = bit0.
    - Mismatch: go to IDLE; no ACK, no drive.
  - ADDR_ACK: at the SCL fall ending the ACK slot, go to WR_BYTE if W.
    - If R, load shift = regs[ptr], go to RD_BYTE, and set sda_oe = ~shift[7] at that same fall.
  - WR_BYTE: shift 8 bits; at the following SCL fall assert the ACK.
    - First byte after the address is the pointer: ptr = byte[PTR_W-1:0]; upper bits are ignored.
    - Each later byte: regs[ptr] = byte. Pulse wr_strobe for one clk with wr_addr=ptr and wr_data=byte, issued on the clk after the 8th rise. Then ptr = ptr+1, wrapping modulo NUM_REGS.
  - WR_ACK: release at the SCL fall ending the slot, return to WR_BYTE. Every byte is ACKed.
  - RD_BYTE: on each SCL fall present the next bit via sda_oe = ~bit. After the 8th bit's fall, release (sda_oe=0) and go to RD_ACK.
  - RD_ACK: sample master ACK on SCL rise.
    - 0 (ACK): ptr = ptr+1 (wrap), load regs[ptr], and drive its MSB at the next fall.
    - 1 (NACK): go to IDLE with sda_oe=0. busy stays 1 until STOP or START.
- Pointer persistence: ptr persists across transactions, so a read without a preceding pointer write continues from the last ptr.
- A write transaction containing only the pointer byte (then repeated START + read) is the standard random-read form and must work.
- Reset mid-transaction: rst wins in the same clk; sda_oe drops immediately; the bus is not re-joined until a fresh START.
- Host port is read-only and has no side effects. It reflects a bus write on the clk after wr_strobe.

Test Plan:
- Write to 0x50 (0xA0): ptr 0x03, data 0xA5, 0x5A, STOP. Required: ACK on all 4 bytes; wr_strobe twice (addr 3/0xA5, addr 4/0x5A); host_rdata[3]=0xA5, [4]=0x5A.
- Random read: write 0xA0,0x03; repeated START; 0xA1; read 2 bytes, ACK then NACK; STOP. Required: 0xA5 then 0x5A on SDA; sda_oe=0 after the NACK.
- Address 0x51 write with data. Required: no ACK (SDA stays 1 in the ACK slot), no wr_strobe, busy stays 0.
- Wrap: ptr 0x0F, write 0x11,0x22. Required: regs[15]=0x11, regs[0]=0x22, wr_addr sequence 15,0.
- STOP after 4 data bits of a write byte. Required: no register change, IDLE, busy=0, sda_oe=0; the next transaction works normally.
- rst asserted while sda_oe=1 during a read byte. Required: sda_oe=0 next clk, all regs 0; address byte ignored until a new START.
